// File: rtl/sat_narrow_pkg.sv
// sat_narrow_pkg: shared constants and the saturation function used by
// sat_narrow and by its reference model.
//   M_DEF / N_DEF / CNT_W_DEF : default widths
//   MAXW                      : widest sample sat_narrow_f can handle
//   sat_narrow_f(value,m,n)   : returns {ovf, val}. val sits in the low n bits.
package sat_narrow_pkg;
  localparam int M_DEF     = 4;
  localparam int N_DEF     = 2;
  localparam int CNT_W_DEF = 8;
  localparam int MAXW      = 64;

  // value is an m-bit signed sample, zero-extended to MAXW bits.
  // The sample fits when bits [m-1:n-1] are all copies of the sign bit.
  // Otherwise it clips to min (sign 1) or max (sign 0).
  function automatic logic [MAXW:0] sat_narrow_f(input logic [MAXW-1:0] value,
                                                  input int m, input int n);
    logic [MAXW-1:0] r;
    logic            sgn;
    logic            same;
    sgn  = value[m-1];
    same = 1'b1;
    r    = '0;
    for (int i = 0; i < MAXW; i++)
      if (i >= n - 1 && i < m && value[i] != sgn) same = 1'b0;
    for (int i = 0; i < MAXW; i++)
      if (i < n) r[i] = same ? value[i] : ((i == n - 1) ? sgn : ~sgn);
    return {~same, r};
  endfunction
endpackage

// File: rtl/sat_narrow_skid_buf.sv
// skid_buf: output register plus one-entry skid register with a registered
// ready. The stream is valid/ready on both sides and has 1-cycle latency.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : upstream handshake (in_ready is registered)
//   in_data [W]           : upstream payload
//   out_valid/out_ready   : downstream handshake
//   out_data [W]          : downstream payload, held stable while stalled
module skid_buf #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] skd_data;
  logic         skd_vld;
  logic         acc, drain, out_free;

  assign acc      = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign out_free = !out_valid || drain;

  // The skid can only fill while the output register is stalled. Ready is
  // therefore low whenever the skid holds data, so the skid never sees an
  // accept while it is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      skd_vld   <= 1'b0;
      skd_data  <= '0;
      in_ready  <= 1'b1;
    end else begin
      if (skd_vld && drain) begin
        out_data <= skd_data;
        skd_vld  <= 1'b0;
        in_ready <= 1'b1;
      end else if (acc && out_free) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else if (acc) begin
        skd_vld  <= 1'b1;
        skd_data <= in_data;
        in_ready <= 1'b0;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/sat_narrow.sv
// sat_narrow: streaming signed narrower. It converts M-bit samples to N bits
// with saturation and flags every clipped sample. It has 1-cycle latency and
// a skid buffer, so it keeps full throughput under backpressure.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_valid/o_ready     : input handshake (o_ready registered)
//   i_val [M]           : input sample, signed
//   o_valid/i_ready     : output handshake
//   o_val [N], o_ovf    : saturated sample and its clip flag
//   o_ovf_cnt [CNT_W]   : saturating count of clipped transfers. This port
//                         exists only when SAT_NARROW_OVF_CNT_EN is defined.
module sat_narrow
  import sat_narrow_pkg::*;
#(
  parameter int M     = M_DEF,
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [M-1:0] i_val,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_val,
  output logic         o_ovf
`ifdef SAT_NARROW_OVF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_ovf_cnt
`endif
);
  logic [MAXW:0] sat_res;
  logic [N:0]    out_pl;
  logic          unused_sat;

  assign sat_res    = sat_narrow_f(MAXW'(i_val), M, N);
  assign unused_sat = ^sat_res[MAXW-1:N];

  skid_buf #(.W(N + 1)) u_skid (
    .clk      (i_clk),
    .rst      (i_rst),
    .in_valid (i_valid),
    .in_ready (o_ready),
    .in_data  ({sat_res[MAXW], sat_res[N-1:0]}),
    .out_valid(o_valid),
    .out_ready(i_ready),
    .out_data (out_pl)
  );

  assign o_ovf = out_pl[N];
  assign o_val = out_pl[N-1:0];

`ifdef SAT_NARROW_OVF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)                                        o_ovf_cnt <= '0;
    else if (o_valid && i_ready && o_ovf && !(&o_ovf_cnt)) o_ovf_cnt <= o_ovf_cnt + 1'b1;
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif
endmodule
